// File: rtl/floating_point_control_if.sv
// Control/datapath handshake bundle for the floating-point sequencer.
// The master side issues requests and returns datapath status; the slave side is the controller.
interface floating_point_control_if;
    logic        start;
    logic        op;
    logic [31:0] floatingPoint1;
    logic [31:0] floatingPoint2;
    logic [24:0] sumSignificand;
    logic        roundOverflow;
    logic        endMultiplication;

    logic        controlToMux01;
    logic        controlToMux02;
    logic        controlToMux03;
    logic        controlToMux04;
    logic        controlToMux05;
    logic [7:0]  controlShiftRight;
    logic [3:0]  controlToIncreaseOrDecrease;
    logic        IncreaseOrDecreaseEnable;
    logic [7:0]  howManyToIncreaseOrDecrease;
    logic        rightOrLeft;
    logic [22:0] howMany;
    logic        isSum;
    logic        sum_sub;
    logic        muxDataRegValor2;
    logic        resetDatapath;
    logic [3:0]  smallALUOperation;
    logic        muxAControlSmall;
    logic        muxBControlSmall;
    logic        loadRegSmall;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, op, floatingPoint1, floatingPoint2,
               sumSignificand, roundOverflow, endMultiplication,
        input  controlToMux01, controlToMux02, controlToMux03, controlToMux04, controlToMux05,
               controlShiftRight, controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable,
               howManyToIncreaseOrDecrease, rightOrLeft, howMany, isSum, sum_sub,
               muxDataRegValor2, resetDatapath, smallALUOperation, muxAControlSmall,
               muxBControlSmall, loadRegSmall, busy, done, error
    );

    modport slave (
        input  start, op, floatingPoint1, floatingPoint2,
               sumSignificand, roundOverflow, endMultiplication,
        output controlToMux01, controlToMux02, controlToMux03, controlToMux04, controlToMux05,
               controlShiftRight, controlToIncreaseOrDecrease, IncreaseOrDecreaseEnable,
               howManyToIncreaseOrDecrease, rightOrLeft, howMany, isSum, sum_sub,
               muxDataRegValor2, resetDatapath, smallALUOperation, muxAControlSmall,
               muxBControlSmall, loadRegSmall, busy, done, error
    );
endinterface

// File: rtl/floating_point_control.sv
// Sequencer for a shared add/multiply floating-point datapath: alignment, compute,
// normalization and rounding-fix control, all outputs registered on state entry.
module floating_point_control (
    input  logic                           clk,
    input  logic                           reset,
    floating_point_control_if.slave        bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_MRESET, S_ALIGN, S_COMPUTE, S_NORM, S_ROUND, S_FIX, S_DONE
    } state_t;

    typedef struct packed {
        logic       mux01;
        logic       mux03;
        logic       mux04;
        logic [7:0] shr;
        logic       sum_sub;
        logic       is_sum;
        logic       mux_val2;
        logic [3:0] small_op;
        logic       mux_ab;
        logic       load_small;
    } sel_t;

    typedef struct packed {
        logic       right;
        logic [4:0] shift;
        logic       en;
    } norm_t;

    localparam logic [5:0] MUL_LAST_CYCLE = 6'd47;
    localparam logic [7:0] MAX_ALIGN      = 8'd26;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [5:0]  cnt_q, cnt_d;
    sel_t        sel_q, sel_d;
    norm_t       norm_q, norm_d, norm_sample;
    logic        fix_q, fix_d;
    logic        rl_q, rl_d;
    logic [22:0] how_q, how_d;
    logic [3:0]  mode_q, mode_d;
    logic        en_q, en_d;
    logic [7:0]  amt_q, amt_d;
    logic        rdp_q, rdp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [7:0]  e1, e2, ediff;
    logic        e1_lt_e2;
    logic [4:0]  lead_pos;
    logic        lead_found;
    logic        unused_mantissas;

    // Only sign and exponent matter to the controller; mantissas live in the datapath.
    assign unused_mantissas = ^{bus.floatingPoint1[22:0], bus.floatingPoint2[22:0]};

    assign e1       = bus.floatingPoint1[30:23];
    assign e2       = bus.floatingPoint2[30:23];
    assign e1_lt_e2 = (e1 < e2);
    assign ediff    = e1_lt_e2 ? (e2 - e1) : (e1 - e2);

    always_comb begin
        lead_pos    = 5'd0;
        lead_found  = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (bus.sumSignificand[i]) begin
                lead_pos   = 5'(i);
                lead_found = 1'b1;
            end
        end
        norm_sample = '0;
        if (bus.sumSignificand[24]) begin
            norm_sample.right = 1'b1;
            norm_sample.shift = 5'd1;
            norm_sample.en    = 1'b1;
        end else if (lead_found) begin
            norm_sample.shift = 5'd23 - lead_pos;
            norm_sample.en    = (lead_pos != 5'd23);
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        norm_d  = norm_q;
        fix_d   = 1'b0;
        rdp_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                sel_d  = '0;
                norm_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
                err_d  = 1'b0;
                if (bus.start) begin
                    op_d   = bus.op;
                    busy_d = 1'b1;
                    if (bus.op) begin
                        state_d = S_MRESET;
                        rdp_d   = 1'b1;
                    end else begin
                        state_d          = S_ALIGN;
                        sel_d.mux01      = e1_lt_e2;
                        sel_d.mux03      = !e1_lt_e2;
                        sel_d.mux04      = e1_lt_e2;
                        sel_d.shr        = (ediff > MAX_ALIGN) ? MAX_ALIGN : ediff;
                        sel_d.sum_sub    = bus.floatingPoint1[31] ^ bus.floatingPoint2[31];
                        sel_d.is_sum     = 1'b1;
                        sel_d.small_op   = 4'b0011;
                        sel_d.load_small = 1'b1;
                    end
                end
            end
            S_MRESET: begin
                if (cnt_q == 6'd0) begin
                    cnt_d = 6'd1;
                    rdp_d = 1'b1;
                end else begin
                    state_d          = S_COMPUTE;
                    cnt_d            = 6'd0;
                    sel_d.mux_val2   = 1'b1;
                    sel_d.small_op   = 4'b0000;
                    sel_d.mux_ab     = 1'b1;
                    sel_d.load_small = 1'b1;
                    sel_d.shr        = 8'd3;
                end
            end
            S_ALIGN: state_d = S_COMPUTE;
            S_COMPUTE: begin
                // Normalization decision is taken on the edge leaving COMPUTE so it is visible in NORM.
                if (!op_q || bus.endMultiplication) begin
                    state_d = S_NORM;
                    norm_d  = norm_sample;
                end else if (cnt_q == MUL_LAST_CYCLE) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_NORM: state_d = S_ROUND;
            S_ROUND: begin
                if (bus.roundOverflow) begin
                    state_d = S_FIX;
                    fix_d   = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                sel_d   = '0;
                norm_d  = '0;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // FIX overrides the held normalization controls for its single cycle only.
        rl_d   = fix_d | norm_d.right;
        how_d  = fix_d ? 23'd1 : {18'd0, norm_d.shift};
        mode_d = (!fix_d && norm_d.en && !norm_d.right) ? 4'b0001 : 4'b0000;
        en_d   = fix_d | norm_d.en;
        amt_d  = fix_d ? 8'd1 : {3'd0, norm_d.shift};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            cnt_q   <= '0;
            sel_q   <= '0;
            norm_q  <= '0;
            fix_q   <= 1'b0;
            rl_q    <= 1'b0;
            how_q   <= '0;
            mode_q  <= '0;
            en_q    <= 1'b0;
            amt_q   <= '0;
            rdp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            norm_q  <= norm_d;
            fix_q   <= fix_d;
            rl_q    <= rl_d;
            how_q   <= how_d;
            mode_q  <= mode_d;
            en_q    <= en_d;
            amt_q   <= amt_d;
            rdp_q   <= rdp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.controlToMux01              = sel_q.mux01;
    assign bus.controlToMux02              = fix_q;
    assign bus.controlToMux03              = sel_q.mux03;
    assign bus.controlToMux04              = sel_q.mux04;
    assign bus.controlToMux05              = fix_q;
    assign bus.controlShiftRight           = sel_q.shr;
    assign bus.controlToIncreaseOrDecrease = mode_q;
    assign bus.IncreaseOrDecreaseEnable    = en_q;
    assign bus.howManyToIncreaseOrDecrease = amt_q;
    assign bus.rightOrLeft                 = rl_q;
    assign bus.howMany                     = how_q;
    assign bus.isSum                       = sel_q.is_sum;
    assign bus.sum_sub                     = sel_q.sum_sub;
    assign bus.muxDataRegValor2            = sel_q.mux_val2;
    assign bus.resetDatapath               = rdp_q;
    assign bus.smallALUOperation           = sel_q.small_op;
    assign bus.muxAControlSmall            = sel_q.mux_ab;
    assign bus.muxBControlSmall            = sel_q.mux_ab;
    assign bus.loadRegSmall                = sel_q.load_small;
    assign bus.busy                        = busy_q;
    assign bus.done                        = done_q;
    assign bus.error                       = err_q;
endmodule

// File: tb/tb_floating_point_control.sv
// Scoreboard bench for floating_point_control: the driver queues expected responses from a
// rule-level model, a negedge monitor pops and compares whenever done is presented.
module tb_floating_point_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    floating_point_control_if bus ();
    floating_point_control dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          op;
        int          lat;
        bit          err;
        bit          fix;
        logic [20:0] sels;
        logic [36:0] norm;
    } exp_t;

    exp_t sb_q[$];

    logic [63:0] all_outs;
    logic [20:0] sels;
    logic [36:0] norm_vec;

    assign all_outs = {bus.controlToMux01, bus.controlToMux02, bus.controlToMux03, bus.controlToMux04,
                       bus.controlToMux05, bus.controlShiftRight, bus.controlToIncreaseOrDecrease,
                       bus.IncreaseOrDecreaseEnable, bus.howManyToIncreaseOrDecrease, bus.rightOrLeft,
                       bus.howMany, bus.isSum, bus.sum_sub, bus.muxDataRegValor2, bus.resetDatapath,
                       bus.smallALUOperation, bus.muxAControlSmall, bus.muxBControlSmall,
                       bus.loadRegSmall, bus.busy, bus.done, bus.error};
    assign sels = {bus.controlToMux01, bus.controlToMux03, bus.controlToMux04, bus.controlShiftRight,
                   bus.sum_sub, bus.isSum, bus.muxDataRegValor2, bus.smallALUOperation,
                   bus.muxAControlSmall, bus.muxBControlSmall, bus.loadRegSmall};
    assign norm_vec = {bus.rightOrLeft, bus.howMany, bus.controlToIncreaseOrDecrease,
                       bus.IncreaseOrDecreaseEnable, bus.howManyToIncreaseOrDecrease};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", name, got, want, $time);
        end
    endtask

    // Expected behaviour straight from the operation rules.
    function automatic exp_t model(bit op, logic [31:0] a, logic [31:0] b, logic [24:0] sig,
                                   bit rovf, int end_k);
        exp_t e;
        int   ea, eb, d, p, sh;
        bit   tmo;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        d  = (ea > eb) ? ea - eb : eb - ea;
        if (d > 26) d = 26;
        if (!op)
            e.sels = {ea < eb, ea >= eb, ea < eb, 8'(d), a[31] ^ b[31], 1'b1, 1'b0, 4'b0011,
                      1'b0, 1'b0, 1'b1};
        else
            e.sels = {3'b000, 8'd3, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b1};
        tmo   = op && (end_k > 48);
        e.op  = op;
        e.err = tmo;
        e.fix = !tmo && rovf;
        if (tmo || sig == 25'd0) begin
            e.norm = '0;
        end else if (sig[24]) begin
            e.norm = {1'b1, 23'd1, 4'd0, 1'b1, 8'd1};
        end else begin
            p  = $clog2(int'(sig) + 1) - 1;
            sh = 23 - p;
            e.norm = {1'b0, 23'(sh), (sh > 0) ? 4'd1 : 4'd0, sh > 0, 8'(sh)};
        end
        if (!op)     e.lat = 5 + int'(e.fix);
        else if (tmo) e.lat = 2 + 48 + 1;
        else         e.lat = 2 + end_k + 3 + int'(e.fix);
        return e;
    endfunction

    // Monitor: tracks one transaction from busy rising to done.
    int          cyc, rdp_cnt, fix_cnt, txn_n;
    bit          in_txn = 1'b0, post_chk = 1'b0;
    logic [20:0] first_sels;
    logic [38:0] fix_vec;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            in_txn   = 1'b0;
            post_chk = 1'b0;
        end else begin
            if (post_chk) begin
                check("idle_outs", all_outs, 64'd0);
                post_chk = 1'b0;
            end
            if (!in_txn && bus.busy) begin
                in_txn  = 1'b1;
                cyc     = 0;
                rdp_cnt = 0;
                fix_cnt = 0;
                fix_vec = '0;
            end
            if (in_txn) begin
                cyc++;
                if (cyc == 1) first_sels = sels;
                if (bus.resetDatapath) rdp_cnt++;
                if (bus.controlToMux02 || bus.controlToMux05) begin
                    fix_cnt++;
                    fix_vec = {bus.controlToMux02, bus.controlToMux05, norm_vec};
                end
                if (bus.done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done at cycle %0d", cyc);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("latency", 64'(cyc), 64'(mon_e.lat));
                        check("error", 64'(bus.error), 64'(mon_e.err));
                        check("busy_at_done", 64'(bus.busy), 64'd1);
                        check("sels_at_done", 64'(sels), 64'(mon_e.sels));
                        check("sels_first_cycle", 64'(first_sels), mon_e.op ? 64'd0 : 64'(mon_e.sels));
                        check("reset_dp_cycles", 64'(rdp_cnt), mon_e.op ? 64'd2 : 64'd0);
                        check("fix_cycles", 64'(fix_cnt), 64'(mon_e.fix));
                        if (mon_e.fix)
                            check("fix_controls", 64'(fix_vec), {25'd0, 2'b11, 1'b1, 23'd1, 4'd0, 1'b1, 8'd1});
                        else
                            check("norm_controls", 64'(norm_vec), 64'(mon_e.norm));
                        txn_n++;
                        $display("txn %0d op=%0d cycles=%0d error=%0d fix=%0d norm=%0h",
                                 txn_n, mon_e.op, cyc, bus.error, fix_cnt, norm_vec);
                    end
                    in_txn   = 1'b0;
                    post_chk = 1'b1;
                end else if (cyc > 120) begin
                    checks++;
                    errors++;
                    $display("FAIL done_missing after %0d cycles", cyc);
                    in_txn = 1'b0;
                end
            end
        end
    end

    task automatic run_txn(input bit op, input logic [31:0] a, input logic [31:0] b,
                           input logic [24:0] sig, input bit rovf, input int end_k,
                           input bit inject, input int rst_at, input bit no_wait);
        exp_t e;
        bit   finished;
        e = model(op, a, b, sig, rovf, end_k);
        if (!no_wait) @(negedge clk);
        bus.start             = 1'b1;
        bus.op                = op;
        bus.floatingPoint1    = a;
        bus.floatingPoint2    = b;
        bus.sumSignificand    = sig;
        bus.roundOverflow     = rovf;
        bus.endMultiplication = 1'b0;
        sb_q.push_back(e);
        finished = 1'b0;
        for (int c = 1; c <= 100 && !finished; c++) begin
            @(negedge clk);
            if (c > 1 && !bus.busy) begin
                bus.start             = 1'b0;
                bus.endMultiplication = 1'b0;
                finished              = 1'b1;
            end else begin
                bus.start = inject && (c == 3 || c == e.lat);
                if (inject && c == 3) begin
                    bus.op             = !op;
                    bus.floatingPoint1 = $urandom;
                    bus.floatingPoint2 = $urandom;
                end
                bus.endMultiplication = op && (end_k <= 48) && (c == 2 + end_k);
                if (rst_at != 0 && c == rst_at) begin
                    #2 reset = 1'b0;
                    #1 check("reset_mid_op", all_outs, 64'd0);
                    void'(sb_q.pop_back());
                    bus.start             = 1'b0;
                    bus.endMultiplication = 1'b0;
                    @(negedge clk);
                    #2 reset = 1'b1;
                    finished = 1'b1;
                end
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL driver_timeout op=%0d", op);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                 = 1'b0;
        bus.start             = 1'b0;
        bus.op                = 1'b0;
        bus.floatingPoint1    = '0;
        bus.floatingPoint2    = '0;
        bus.sumSignificand    = '0;
        bus.roundOverflow     = 1'b0;
        bus.endMultiplication = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", all_outs, 64'd0);
        #2 reset = 1'b1;

        // Directed cases.
        run_txn(1'b0, 32'h3F40_0000, 32'h4010_0000, 25'h0C0_0000, 1'b0, 0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h41FC_0000, 32'hC088_0000, 25'h05A_0000, 1'b0, 0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h4040_0000, 32'h40A0_0000, 25'h180_0000, 1'b0, 10, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h3F80_0000, 32'h3F80_0000, 25'h100_0000, 1'b1, 0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h4000_0000, 32'h4000_0000, 25'h0A0_0000, 1'b1, 49, 1'b1, 0, 1'b0);
        run_txn(1'b1, 32'hC000_0000, 32'h4000_0000, 25'h000_0003, 1'b1, 48, 1'b0, 0, 1'b0);
        run_txn(1'b0, 32'h0080_0000, 32'hFF00_0000, 25'h000_0000, 1'b0, 0, 1'b1, 0, 1'b0);
        run_txn(1'b0, 32'hBF80_0000, 32'h3F80_0001, 25'h000_0001, 1'b0, 0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 32'h3F80_0000, 32'h3F80_0000, 25'h080_0000, 1'b1, 1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int          k;
            int          ek;
            logic [24:0] sig;
            k   = int'($urandom_range(0, 25));
            sig = (k == 25) ? 25'd0 : ((25'h1 << k) | (25'($urandom) & ((25'h1 << k) - 25'h1)));
            ek  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 52)) : int'($urandom_range(1, 12));
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, sig, 1'($urandom_range(0, 1)),
                    ek, 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        // Reset while the multiplier is in COMPUTE, then start on the first edge after release.
        run_txn(1'b1, 32'h4100_0000, 32'h4100_0000, 25'h080_0000, 1'b0, 20, 1'b0, 5, 1'b0);
        run_txn(1'b0, 32'h3F40_0000, 32'h4010_0000, 25'h040_0000, 1'b1, 0, 1'b0, 0, 1'b1);
        run_txn(1'b1, 32'h3F80_0000, 32'h4080_0000, 25'h100_0001, 1'b0, 4, 1'b1, 0, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/floating_point_control.md
FLOATING_POINT_CONTROL -- requirements
Module: floating_point_control

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL: start  in  1  request pulse; accepted only in IDLE.
REQ-004 SHALL: op  in  1  0 = add, 1 = multiply; sampled with start.
REQ-005 SHALL: floatingPoint1, floatingPoint2  in  32 each  IEEE-754 single operands; sampled with start.
REQ-006 SHALL: sumSignificand  in  25  datapath big-ALU result; bit24 = carry, bit23 = hidden-bit position.
REQ-007 SHALL: roundOverflow  in  1  datapath rounder carried into bit24.
REQ-008 SHALL: endMultiplication  in  1  datapath multiplier finished.
REQ-009 SHALL: controlToMux01..controlToMux05  out  1 each  datapath mux selects.
REQ-010 SHALL: controlShiftRight  out  8  alignment shift amount.
REQ-011 SHALL: controlToIncreaseOrDecrease  out  4  exponent adjust mode (0000 = increase, 0001 = decrease).
REQ-012 SHALL: IncreaseOrDecreaseEnable  out  1 / howManyToIncreaseOrDecrease  out  8  exponent adjust enable and amount.
REQ-013 SHALL: rightOrLeft  out  1 (1 = right) / howMany  out  23  normalization shift direction and amount.
REQ-014 SHALL: isSum, sum_sub, muxDataRegValor2, resetDatapath  out  1 each  big-ALU controls; resetDatapath is active-high.
REQ-015 SHALL: smallALUOperation  out  4 / muxAControlSmall, muxBControlSmall, loadRegSmall  out  1 each  small-ALU controls.
REQ-016 SHALL: busy, done, error  out  1 each  status.

Function
REQ-017 SHALL: states IDLE, MRESET, ALIGN, COMPUTE, NORM, ROUND, FIX, DONE.
REQ-018 SHALL: IDLE with start=1 -> latch operands and op, set busy=1; add -> ALIGN, mul -> MRESET.
REQ-019 SHALL: start while busy=1 is ignored; operands are not re-latched.
REQ-020 SHALL: behaviour in ALIGN (1 cycle, add only):
- e1 < e2 -> mux01=1, mux03=0, mux04=1; otherwise mux01=0, mux03=1, mux04=0.
- controlShiftRight = min(|e1-e2|, 26).
- sum_sub = s1 XOR s2; isSum=1.
- smallALUOperation=0011; muxA/BControlSmall=0; loadRegSmall=1.
REQ-021 SHALL: MRESET (mul only) lasts exactly 2 cycles with resetDatapath=1 and muxDataRegValor2=0.
REQ-022 SHALL: entering COMPUTE for mul -> isSum=0, muxDataRegValor2=1, smallALUOperation=0000, muxA/BControlSmall=1, loadRegSmall=1, controlShiftRight=3.
REQ-023 SHALL: selections from REQ-020/022 are held from their first cycle through DONE and cleared in IDLE.
REQ-024 SHALL: COMPUTE lasts 1 cycle for add; for mul it waits for endMultiplication=1.
REQ-025 SHALL: mul timeout: 48 COMPUTE cycles without endMultiplication -> DONE with error=1.
REQ-026 SHALL: NORM (1 cycle) samples sumSignificand:
- bit24=1 -> right shift 1, increase exponent by 1.
- else leading one at bit p<=23 -> left shift 23-p, decrease exponent by 23-p (no shift and enable=0 when p=23).
- all zero -> no shift, enable=0.
REQ-027 SHALL: normalization controls are held from NORM through DONE.
REQ-028 SHALL: ROUND (1 cycle) -> FIX if roundOverflow=1, else DONE.
REQ-029 SHALL: FIX (1 cycle) drives mux02=1, mux05=1, rightOrLeft=1, howMany=1, increase exponent by 1, then -> DONE.
REQ-030 SHALL: DONE asserts done=1 for exactly one cycle, then -> IDLE with busy=0.
REQ-031 SHALL: add latency = done 5 cycles after the accepting edge, 6 if FIX; mul latency = 2 + COMPUTE cycles + 3 (+1 if FIX).
REQ-032 SHALL: every output not explicitly driven by the current state is 0.

Reset
REQ-033 SHALL: reset=0 at any time, including mid-operation, forces IDLE and drives all outputs to 0 immediately.
REQ-034 SHALL: the first start is accepted on the first rising edge after reset deasserts.

Verification
REQ-035 SHALL: add 0.75 + 2.25 -> ALIGN mux01=1, mux04=1, controlShiftRight=2, sum_sub=0; done at cycle 5.
REQ-036 SHALL: add 31.5 + (-4.25) -> mux03=1, controlShiftRight=2, sum_sub=1; sumSignificand bit22 leading -> left 1, decrease 1.
REQ-037 SHALL: mul with endMultiplication at 10th COMPUTE cycle -> resetDatapath high 2 cycles, muxDataRegValor2=1, done 15 cycles after accept, error=0.
REQ-038 SHALL: add with roundOverflow=1 in ROUND -> FIX asserts mux02=1, mux05=1, increase 1; done at cycle 6.
REQ-039 SHALL: mul with endMultiplication never asserted -> error=1 and done after 48 COMPUTE cycles; start during busy is ignored.
REQ-040 SHALL: reset asserted in COMPUTE -> all outputs 0 that cycle; next start proceeds normally.
